// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter sharing one combinational 25-tap-plus-bias adder tree
// among NUM_REQ requesters; returns each sum with its requester ID.
module adder_tree_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_OPS    = 26,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*NUM_OPS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_OPS*DATA_WIDTH-1:0]         tree_operands,
    input  logic [DATA_WIDTH-1:0]                 tree_result,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_WIDTH-1:0]                 rsp_data,
    output logic [ID_WIDTH-1:0]                   rsp_id,
    output logic                                  busy
);

    localparam int unsigned OPS_W  = NUM_OPS * DATA_WIDTH;
    localparam int unsigned CAND_W = ID_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [OPS_W-1:0]      ops_q, ops_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  busy_q, busy_d;

    logic [OPS_W-1:0]      req_slice [NUM_REQ];
    logic [ID_WIDTH-1:0]   winner_c;
    logic                  any_c;
    logic [CAND_W-1:0]     cand_c;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice[g] = req_data[g*OPS_W +: OPS_W];
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        any_c    = 1'b0;
        winner_c = '0;
        cand_c   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand_c = {1'b0, last_grant_q} + CAND_W'(off);
            if (cand_c >= CAND_W'(NUM_REQ)) begin
                cand_c = cand_c - CAND_W'(NUM_REQ);
            end
            if (!any_c && req_valid[cand_c[ID_WIDTH-1:0]]) begin
                any_c    = 1'b1;
                winner_c = cand_c[ID_WIDTH-1:0];
            end
        end
    end

    // Next-state and grant logic; grants only leave IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ops_d        = ops_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    req_ready    = NUM_REQ'(1) << winner_c;
                    ops_d        = req_slice[winner_c];
                    rsp_id_d     = winner_c;
                    last_grant_d = winner_c;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                rsp_data_d  = tree_result;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            ops_q        <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ops_q        <= ops_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign tree_operands = ops_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_valid     = rsp_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter: real adder tree model, scenario tasks, and a
// response scoreboard keyed on requester ID.
module tb_adder_tree_arbiter;

    localparam int unsigned DW  = 16;
    localparam int unsigned NR  = 4;
    localparam int unsigned NO  = 26;
    localparam int unsigned IDW = 2;

    logic                  clk;
    logic                  reset_n;
    logic [NR-1:0]         req_valid;
    logic [NR*NO*DW-1:0]   req_data;
    logic [NR-1:0]         req_ready;
    logic [NO*DW-1:0]      tree_operands;
    logic [DW-1:0]         tree_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DW-1:0]         rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    logic [DW-1:0] ops [NR][NO];

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    adder_tree_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_OPS(NO), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tree_operands(tree_operands), .tree_result(tree_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference adder tree: 25 products plus bias, wrapping at DW bits.
    always_comb begin
        tree_result = '0;
        for (int k = 0; k < NO; k++) tree_result = tree_result + tree_operands[k*DW +: DW];
    end

    always_comb begin
        req_data = '0;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NO; k++)
                req_data[(r*NO + k)*DW +: DW] = ops[r][k];
    end

    function automatic logic [DW-1:0] exp_sum(input int r);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < NO; k++) s = s + ops[r][k];
        return s;
    endfunction

    // Scoreboard: every response handshake must match the oldest expected grant.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_id !== mon_e.id || rsp_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL rsp_scoreboard: got id=%0d data=%h, required id=%0d data=%h",
                             rsp_id, rsp_data, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got req_ready=%b busy=%b rsp_valid=%b, required 0000 0 0", req_ready, busy, rsp_valid);
        end
        checks++;
        if (rsp_data !== 16'h0000 || rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_rsp: got data=%h id=%0d, required 0000 0", rsp_data, rsp_id);
        end
        checks++;
        if (tree_operands !== '0) begin
            failures++;
            $display("FAIL reset_ops: got %h, required 0", tree_operands);
        end
        next_drive();
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int n;
        int prev;
        logic [NR-1:0] g;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NO; k++) ops[r][k] = 16'(r*1000 + k*7 + 1);
        next_drive();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        n = 0;
        prev = 0;
        for (int i = 0; i < 24 && n < 5; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                g = 4'(1 << (n % 4));
                checks++;
                if (req_ready !== g) begin
                    failures++;
                    $display("FAIL rr_order%0d: got req_ready=%b, required %b", n, req_ready, g);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - prev !== 3) begin
                        failures++;
                        $display("FAIL rr_spacing%0d: got %0d cycles, required 3", n, cyc - prev);
                    end
                end
                sb.push_back({2'(n % 4), exp_sum(n % 4)});
                prev = cyc;
                n++;
                if (n == 5) begin
                    next_drive();
                    req_valid = '0;
                end
            end
        end
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL rr_timeout: got %0d grants, required 5", n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        for (int k = 0; k < NO - 1; k++) ops[0][k] = 16'd1;
        ops[0][NO-1] = 16'd0;
        next_drive();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: got %b, required 0001", req_ready);
        end
        sb.push_back({2'd0, exp_sum(0)});
        next_drive();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_settle: got busy=%b rsp_valid=%b, required 1 0", busy, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd25 || rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL single_rsp: got valid=%b data=%0d id=%0d, required 1 25 0", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [NO*DW-1:0] exp_ops;
        logic [NO*DW-1:0] t0;
        logic [DW-1:0]    d0;
        logic [IDW-1:0]   i0;
        for (int k = 0; k < NO; k++) begin
            ops[1][k] = 16'(16'h0100 + k);
            ops[2][k] = 16'(16'h0200 + 3*k);
            exp_ops[k*DW +: DW] = 16'(16'h0100 + k);
        end
        next_drive();
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant: got %b, required 0010", req_ready);
        end
        sb.push_back({2'd1, exp_sum(1)});
        next_drive();
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_settle_ready: got %b, required 0000", req_ready);
        end
        @(negedge clk);
        t0 = tree_operands;
        d0 = rsp_data;
        i0 = rsp_id;
        checks++;
        if (rsp_valid !== 1'b1 || t0 !== exp_ops || i0 !== 2'd1 || d0 !== exp_sum(1)) begin
            failures++;
            $display("FAIL bp_first: got valid=%b id=%0d data=%h ops=%h, required 1 1 %h %h",
                     rsp_valid, i0, d0, t0, exp_sum(1), exp_ops);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== i0 || tree_operands !== t0 || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h id=%0d ready=%b, required 1 %h %0d 0000",
                         i, rsp_valid, rsp_data, rsp_id, req_ready, d0, i0);
            end
        end
        next_drive();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_regrant: got ready=%b rsp_valid=%b, required 0100 0", req_ready, rsp_valid);
        end
        sb.push_back({2'd2, exp_sum(2)});
        next_drive();
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < NO - 1; k++) ops[3][k] = 16'h7FFF;
        ops[3][NO-1] = 16'h0001;
        next_drive();
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_grant: got %b, required 1000", req_ready);
        end
        sb.push_back({2'd3, exp_sum(3)});
        next_drive();
        req_valid = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h7FE8 || rsp_id !== 2'd3) begin
            failures++;
            $display("FAIL wrap_sum: got valid=%b data=%h id=%0d, required 1 7fe8 3", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int n;
        logic [NR-1:0] g;
        logic [NR-1:0] exp_g;
        next_drive();
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL fair_first: got %b, required 0100", req_ready);
        end
        sb.push_back({2'd2, exp_sum(2)});
        next_drive();
        req_valid = 4'b1010;
        n = 0;
        for (int i = 0; i < 16 && n < 2; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                g = req_ready;
                exp_g = (n == 0) ? 4'b1000 : 4'b0010;
                checks++;
                if (g !== exp_g) begin
                    failures++;
                    $display("FAIL fair_order%0d: got %b, required %b", n, g, exp_g);
                end
                if (n == 0) sb.push_back({2'd3, exp_sum(3)});
                else        sb.push_back({2'd1, exp_sum(1)});
                n++;
                next_drive();
                req_valid = req_valid & ~g;
            end
        end
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL fair_timeout: got %0d grants, required 2", n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < NO - 1; k++) ops[0][k] = 16'd1;
        ops[0][NO-1] = 16'd0;
        next_drive();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_grant: got %b, required 0001", req_ready);
        end
        next_drive();
        req_valid = '0;
        reset_n   = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 2'd0 ||
            tree_operands !== '0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rmid_clear: got busy=%b valid=%b data=%h id=%0d ready=%b ops_nonzero=%b, required all 0",
                     busy, rsp_valid, rsp_data, rsp_id, req_ready, |tree_operands);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_no_rsp: got rsp_valid=%b, required 0", rsp_valid);
        end
        next_drive();
        reset_n   = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_regrant: got ready=%b busy=%b valid=%b, required 0001 0 0", req_ready, busy, rsp_valid);
        end
        sb.push_back({2'd0, exp_sum(0)});
        next_drive();
        req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NO; k++) ops[r][k] = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_wrap();
        test_fairness();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending responses, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adder_tree_arbiter.md
Name: adder_tree_arbiter

Overview:
Shares one combinational 25-tap-plus-bias adder tree among NUM_REQ convolution requesters. Round-robin arbitration picks one requester at a time. The winner's 26 operands are registered onto the tree inputs, the tree result is captured one cycle later, and the result is returned with the requester ID over a valid/ready response channel. The block sits between the per-channel multiplier arrays and the output/activation stage.

Parameters:
DATA_WIDTH, 16, width of each operand and of the result (signed two's complement)
NUM_REQ, 4, number of requesters (2..8)
NUM_OPS, 26, operands per request: 25 products followed by bias (fixed to the tree's arity)
ID_WIDTH, 2, width of rsp_id; must equal clog2(NUM_REQ)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_data  input  NUM_REQ*NUM_OPS*DATA_WIDTH  requester r occupies slice r; operand k at [k*DATA_WIDTH +: DATA_WIDTH]; k=25 is bias
req_ready  output  NUM_REQ  one-hot grant; asserted only in IDLE, for the winner only
tree_operands  output  NUM_OPS*DATA_WIDTH  registered operands to the adder tree (operand 0..24 -> data_in_0..24, 25 -> bias)
tree_result  input  DATA_WIDTH  adder tree sum
rsp_valid  output  1  response valid
rsp_ready  input  1  downstream accepts response
rsp_data  output  DATA_WIDTH  captured sum
rsp_id  output  ID_WIDTH  index of requester the response belongs to
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, last_grant=NUM_REQ-1 (requester 0 has top priority first), tree_operands=0, rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0.
- Reset mid-transaction discards the in-flight request; no response is ever produced for it.
- FSM states: IDLE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - Winner = first r with req_valid[r]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; a handshake is req_valid & req_ready.
  - On handshake: latch the winner's req_data into tree_operands, latch the winner into rsp_id and last_grant, go to SETTLE.
  - If no req_valid: stay in IDLE; all outputs are held.
- SETTLE: exactly one cycle; tree_operands are stable. At the end of the cycle, rsp_data <= tree_result, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and tree_operands are held stable.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - No grant is issued in the same cycle as the response handshake.
- Latency: request handshake at cycle C gives rsp_valid=1 at cycle C+2. With rsp_ready=1, the next grant is possible at C+3. Peak throughput is 1 result per 3 cycles.
- req_ready is 0 in SETTLE and RESP. A requester must hold req_valid and req_data stable until granted. Deasserting req_valid before a grant withdraws the request with no side effect.
- Arithmetic: the block performs no arithmetic. rsp_data is tree_result bit-exact, so the tree's modulo-2^DATA_WIDTH wrap is passed through unchanged.
- Simultaneous requests are resolved solely by the round-robin order. No requester waits more than NUM_REQ-1 grants.
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
1. Bench instantiates the real adder tree on tree_operands/tree_result. Requester 0 only: operands 0..24 = 1, bias = 0, request at cycle C, rsp_ready=1 -> req_ready=4'b0001 at C; rsp_valid=1, rsp_data=25, rsp_id=0 at C+2; busy=0 at C+3.
2. All four req_valid held high, distinct data, rsp_ready=1 -> grants in order 0,1,2,3,0 at cycles C, C+3, C+6, C+9, C+12; each rsp_id matches its grant.
3. Backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_valid, rsp_data, rsp_id and tree_operands constant, req_ready=0. rsp_ready=1 -> handshake, then a grant one cycle later.
4. Wrap: operands 0..24 = 0x7FFF, bias = 0x0001 -> rsp_data = 0x7FE8 (819176 mod 65536).
5. Fairness: after a grant to requester 2, requesters 1 and 3 request simultaneously -> 3 is granted, then 1.
6. Reset pulse during SETTLE -> all outputs 0 immediately, rsp_valid never asserted for that request. After release with all requesting -> requester 0 is granted first.
